des_key_sequencer: RTL and testbench

Sequencer for the triple-DES subkey generator and its Feistel round datapath. It accepts one 64-bit block job at a time and steps the generator through three 17-cycle key phases. For that it drives `round_count`, `key_count`, `cnt_rollover`, `key_rollover` and `reverse`. It also tells the round datapath which cycles carry a valid subkey and when the job is finished.

---
 rtl/des_key_sequencer.sv | 139 +++++++++++++
 tb/tb_des_key_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : des_key_sequencer
// Description : Job sequencer for a triple-DES subkey generator and Feistel
//               round datapath. It steps three 17-cycle key phases per block
//               and flags which cycles carry a valid subkey.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_sequencer #(
  parameter int ROUNDS = 16,
  parameter int PHASES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_decrypt,
  output logic       in_ready,
  output logic [4:0] round_count,
  output logic [1:0] key_count,
  output logic       cnt_rollover,
  output logic       key_rollover,
  output logic       reverse,
  output logic       subkey_valid,
  output logic [3:0] subkey_num,
  output logic       phase_decrypt,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] c_last_round = 5'(ROUNDS);
  localparam logic [1:0] c_last_phase = 2'(PHASES - 1);

  state_t     state_q, state_d;
  logic [4:0] round_count_q, round_count_d;
  logic [1:0] key_count_q, key_count_d;
  logic       reverse_q, reverse_d;
  logic       subkey_valid_q, subkey_valid_d;
  logic [3:0] subkey_num_q, subkey_num_d;
  logic       phase_decrypt_q, phase_decrypt_d;
  logic       w_in_round;
  logic       w_cnt_roll;
  logic       w_key_roll;

  // Rollover flags are decodes of the registered counters, only live in ROUND
  always_comb begin
    w_in_round = (state_q == S_ROUND);
    w_cnt_roll = w_in_round && (round_count_q == c_last_round);
    w_key_roll = w_cnt_roll && (key_count_q == c_last_phase);
  end

  // Next-state and counter logic; the round counter never stalls in ROUND
  // because the generator shifts its key registers every cycle.
  always_comb begin
    state_d         = state_q;
    round_count_d   = round_count_q;
    key_count_d     = key_count_q;
    reverse_d       = reverse_q;
    subkey_valid_d  = w_in_round && (round_count_q != 5'd0);
    subkey_num_d    = w_in_round ? 4'(round_count_q - 5'd1) : 4'd0;
    phase_decrypt_d = w_in_round && (reverse_q ^ (key_count_q == 2'd1));

    case (state_q)
      S_IDLE: begin
        round_count_d = 5'd0;
        key_count_d   = 2'd0;
        if (in_valid) begin
          reverse_d = in_decrypt;
          state_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        if (w_cnt_roll) begin
          round_count_d = 5'd0;
          if (w_key_roll) begin
            key_count_d = 2'd0;
            state_d     = S_FLUSH;
          end else begin
            key_count_d = key_count_q + 2'd1;
          end
        end else begin
          round_count_d = round_count_q + 5'd1;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An out-of-range phase can only come from an upset; recover to idle.
    if (key_count_q > c_last_phase) begin
      state_d       = S_IDLE;
      round_count_d = 5'd0;
      key_count_d   = 2'd0;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      round_count_q   <= 5'd0;
      key_count_q     <= 2'd0;
      reverse_q       <= 1'b0;
      subkey_valid_q  <= 1'b0;
      subkey_num_q    <= 4'd0;
      phase_decrypt_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      round_count_q   <= round_count_d;
      key_count_q     <= key_count_d;
      reverse_q       <= reverse_d;
      subkey_valid_q  <= subkey_valid_d;
      subkey_num_q    <= subkey_num_d;
      phase_decrypt_q <= phase_decrypt_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign round_count   = round_count_q;
  assign key_count     = key_count_q;
  assign cnt_rollover  = w_cnt_roll;
  assign key_rollover  = w_key_roll;
  assign reverse       = reverse_q;
  assign subkey_valid  = subkey_valid_q;
  assign subkey_num    = subkey_num_q;
  assign phase_decrypt = phase_decrypt_q;

endmodule
`default_nettype wire

// File: tb/tb_des_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_key_sequencer
// Description : Directed self-checking bench for des_key_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_decrypt;
  logic       in_ready;
  logic [4:0] round_count;
  logic [1:0] key_count;
  logic       cnt_rollover;
  logic       key_rollover;
  logic       reverse;
  logic       subkey_valid;
  logic [3:0] subkey_num;
  logic       phase_decrypt;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  des_key_sequencer #(.ROUNDS(16), .PHASES(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_decrypt   (in_decrypt),
    .in_ready     (in_ready),
    .round_count  (round_count),
    .key_count    (key_count),
    .cnt_rollover (cnt_rollover),
    .key_rollover (key_rollover),
    .reverse      (reverse),
    .subkey_valid (subkey_valid),
    .subkey_num   (subkey_num),
    .phase_decrypt(phase_decrypt),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a request in the current idle cycle; returns in cycle T+1
  task automatic accept_job(input logic d);
    in_valid   = 1'b1;
    in_decrypt = d;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_in_ready: got %b want 1", in_ready);
    end
    step();
  endtask

  // Walk cycles T+1..T+53 checking every output; ends in the DONE cycle
  task automatic check_job(input logic d, input bit keep_valid, input string tag);
    int sv_total, cnt_total, key_total;
    int p, r, j, q, idx;
    logic [4:0] e_rc;
    logic [1:0] e_kc;
    logic e_cnt, e_key, e_sv, e_pd;
    logic [3:0] e_num;
    sv_total = 0; cnt_total = 0; key_total = 0;
    for (int k = 1; k <= 53; k++) begin
      if (k <= 51) begin
        p = (k - 1) / 17; r = (k - 1) % 17;
        e_rc = 5'(r); e_kc = 2'(p);
        e_cnt = (r == 16); e_key = (r == 16) && (p == 2);
      end else begin
        e_rc = 5'd0; e_kc = 2'd0; e_cnt = 1'b0; e_key = 1'b0;
      end
      e_sv = 1'b0; e_num = 4'd0; e_pd = 1'b0;
      if (k >= 3 && k <= 52) begin
        j = k - 3; q = j / 17; idx = j % 17;
        if (idx <= 15) begin
          e_sv = 1'b1; e_num = 4'(idx); e_pd = d ^ (q == 1);
        end
      end
      if (subkey_valid === 1'b1) sv_total++;
      if (cnt_rollover === 1'b1) cnt_total++;
      if (key_rollover === 1'b1) key_total++;

      checks++;
      if (round_count !== e_rc) begin
        errors++;
        $display("FAIL %s round_count T+%0d: got %0d want %0d", tag, k, round_count, e_rc);
      end
      checks++;
      if (key_count !== e_kc) begin
        errors++;
        $display("FAIL %s key_count T+%0d: got %0d want %0d", tag, k, key_count, e_kc);
      end
      checks++;
      if (cnt_rollover !== e_cnt) begin
        errors++;
        $display("FAIL %s cnt_rollover T+%0d: got %b want %b", tag, k, cnt_rollover, e_cnt);
      end
      checks++;
      if (key_rollover !== e_key) begin
        errors++;
        $display("FAIL %s key_rollover T+%0d: got %b want %b", tag, k, key_rollover, e_key);
      end
      checks++;
      if (subkey_valid !== e_sv) begin
        errors++;
        $display("FAIL %s subkey_valid T+%0d: got %b want %b", tag, k, subkey_valid, e_sv);
      end
      if (e_sv) begin
        checks++;
        if (subkey_num !== e_num) begin
          errors++;
          $display("FAIL %s subkey_num T+%0d: got %0d want %0d", tag, k, subkey_num, e_num);
        end
        checks++;
        if (phase_decrypt !== e_pd) begin
          errors++;
          $display("FAIL %s phase_decrypt T+%0d: got %b want %b", tag, k, phase_decrypt, e_pd);
        end
      end
      checks++;
      if (out_valid !== (k == 53)) begin
        errors++;
        $display("FAIL %s out_valid T+%0d: got %b want %b", tag, k, out_valid, (k == 53));
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s in_ready T+%0d: got %b want 0", tag, k, in_ready);
      end
      checks++;
      if (reverse !== d) begin
        errors++;
        $display("FAIL %s reverse T+%0d: got %b want %b", tag, k, reverse, d);
      end
      if (k == 1 && !keep_valid) in_valid = 1'b0;
      if (k < 53) step();
    end
    checks++;
    if (sv_total != 48) begin
      errors++;
      $display("FAIL %s subkey_valid_total: got %0d want 48", tag, sv_total);
    end
    checks++;
    if (cnt_total != 3 || key_total != 1) begin
      errors++;
      $display("FAIL %s rollover_totals: got cnt=%0d key=%0d want cnt=3 key=1", tag, cnt_total, key_total);
    end
  endtask

  // Check every output against its reset/idle value
  task automatic check_idle(input string tag);
    checks++;
    if (in_ready !== 1'b1 || round_count !== 5'd0 || key_count !== 2'd0 ||
        cnt_rollover !== 1'b0 || key_rollover !== 1'b0 || subkey_valid !== 1'b0 ||
        subkey_num !== 4'd0 || phase_decrypt !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_outputs: got rdy=%b rc=%0d kc=%0d cr=%b kr=%b sv=%b sn=%0d pd=%b ov=%b want rdy=1 rest 0",
               tag, in_ready, round_count, key_count, cnt_rollover, key_rollover,
               subkey_valid, subkey_num, phase_decrypt, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b1;
    step(); step();
    check_idle("reset");
    checks++;
    if (reverse !== 1'b0) begin
      errors++;
      $display("FAIL reset reverse: got %b want 0", reverse);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_idle("idle20");
    end
  endtask

  task automatic test_encrypt();
    out_ready = 1'b1;
    accept_job(1'b0);
    check_job(1'b0, 1'b0, "enc");
    step();
    check_idle("enc_after");
  endtask

  task automatic test_decrypt();
    out_ready = 1'b1;
    accept_job(1'b1);
    check_job(1'b1, 1'b0, "dec");
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || reverse !== 1'b1) begin
      errors++;
      $display("FAIL dec_after: got rdy=%b ov=%b rev=%b want 1 0 1", in_ready, out_valid, reverse);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    accept_job(1'b0);
    check_job(1'b0, 1'b1, "bp");
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got ov=%b rdy=%b want ov=1 rdy=0", i, out_valid, in_ready);
      end
    end
    out_ready  = 1'b1;
    in_decrypt = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
    step();
    checks++;
    if (in_ready !== 1'b0 || reverse !== 1'b1 || round_count !== 5'd0) begin
      errors++;
      $display("FAIL bp_reaccept: got rdy=%b rev=%b rc=%0d want 0 1 0", in_ready, reverse, round_count);
    end
    check_job(1'b1, 1'b0, "bp2");
    step();
    check_idle("bp2_after");
  endtask

  task automatic test_reset_mid();
    int ov_seen;
    out_ready = 1'b1;
    accept_job(1'b1);
    in_valid = 1'b0;
    for (int k = 1; k < 25; k++) step();
    checks++;
    if (round_count !== 5'd7 || key_count !== 2'd1) begin
      errors++;
      $display("FAIL midrst_pre: got rc=%0d kc=%0d want rc=7 kc=1", round_count, key_count);
    end
    rst = 1'b1;
    #1;
    check_idle("midrst_async");
    checks++;
    if (reverse !== 1'b0) begin
      errors++;
      $display("FAIL midrst_reverse: got %b want 0", reverse);
    end
    ov_seen = 0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) ov_seen++;
    end
    checks++;
    if (ov_seen != 0) begin
      errors++;
      $display("FAIL midrst_no_out_valid: got %0d cycles high want 0", ov_seen);
    end
    accept_job(1'b0);
    check_job(1'b0, 1'b0, "postrst");
    step();
    check_idle("postrst_after");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    accept_job(1'b0);
    check_job(1'b0, 1'b1, "b2b1");
    in_decrypt = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap in_ready T+54: got %b want 1", in_ready);
    end
    step();
    check_job(1'b1, 1'b1, "b2b2");
    in_valid = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end in_ready: got %b want 1", in_ready);
    end
    step();
    check_idle("b2b_idle");
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
